range_rand_gen: RTL and testbench

RANGE_RAND_GEN -- requirements
Module: range_rand_gen

---
 rtl/rr_pkg.sv | 15 +
 rtl/lfsr8.sv | 37 +++
 rtl/range_rand_gen.sv | 127 ++++++++++++
 tb/tb_range_rand_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// Shared types and constants for the bounded-range random generator.
package rr_pkg;

    localparam int DATA_W = 8;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
    localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_RESP = 2'd2
    } rr_state_e;

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR; steps only when en is high.
// Latency: new value visible one cycle after an enabled edge; no backpressure.
module lfsr8
    import rr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] seed_nz;

    // An all-zero state would lock the register, so a zero seed is replaced.
    assign seed_nz = (seed == '0) ? DATA_W'(1) : seed;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {q_q[DATA_W-2:0], ^(q_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= seed_nz;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/range_rand_gen.sv
// Returns a pseudo-random value in [lo,hi] by LFSR rejection sampling, with bypass/error/fallback.
// Latency 1 cycle for err/bypass, 2..MAX_TRIES+1 for generated; response held until rsp_ready.
module range_rand_gen
    import rr_pkg::*;
#(
    parameter logic [7:0] SEED      = 8'hA5,
    parameter int         THRESH    = 10,
    parameter int         MAX_TRIES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_bypass,
    output logic              rsp_err,
    output logic              rsp_fallback
);

    localparam int                TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]  LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);

    rr_state_e         state_q;
    logic              ready_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              byp_q;
    logic              fb_q;
    logic [TRY_W-1:0]  try_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lfsr;
    logic              hit;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == S_GEN),
        .seed  (SEED),
        .q     (lfsr)
    );

    assign hit = (lfsr >= lo_q) && (lfsr <= hi_q);

    // req_ready is registered so it stays low through reset and rises the cycle after.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            byp_q   <= 1'b0;
            fb_q    <= 1'b0;
            try_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        lo_q    <= lo;
                        hi_q    <= hi;
                        try_q   <= '0;
                        if (lo > hi) begin
                            state_q <= S_RESP;
                            valid_q <= 1'b1;
                            data_q  <= '0;
                            err_q   <= 1'b1;
                        end else if (lo <= THRESH_V) begin
                            state_q <= S_RESP;
                            valid_q <= 1'b1;
                            data_q  <= '0;
                            byp_q   <= 1'b1;
                        end else begin
                            state_q <= S_GEN;
                        end
                    end
                end
                S_GEN: begin
                    if (hit) begin
                        state_q <= S_RESP;
                        valid_q <= 1'b1;
                        data_q  <= lfsr;
                    end else if (try_q == LAST_TRY) begin
                        state_q <= S_RESP;
                        valid_q <= 1'b1;
                        data_q  <= lo_q;
                        fb_q    <= 1'b1;
                    end else begin
                        try_q <= try_q + TRY_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        err_q   <= 1'b0;
                        byp_q   <= 1'b0;
                        fb_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = ready_q;
    assign rsp_valid    = valid_q;
    assign rsp_data     = data_q;
    assign rsp_err      = err_q;
    assign rsp_bypass   = byp_q;
    assign rsp_fallback = fb_q;

endmodule

// File: tb/tb_range_rand_gen.sv
// Bench for range_rand_gen: fixed vector table, randomized requests against a polynomial-level model.
module tb_range_rand_gen;

    localparam logic [7:0] SEED      = 8'hA5;
    localparam int         THRESH    = 10;
    localparam int         MAX_TRIES = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] lo = '0;
    logic [7:0] hi = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_bypass;
    logic       rsp_err;
    logic       rsp_fallback;
    logic [2:0] flags;

    int tests = 0;
    int fails = 0;
    logic [7:0] ml;

    range_rand_gen #(.SEED(SEED), .THRESH(THRESH), .MAX_TRIES(MAX_TRIES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .lo           (lo),
        .hi           (hi),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_bypass   (rsp_bypass),
        .rsp_err      (rsp_err),
        .rsp_fallback (rsp_fallback)
    );

    always #5 clk = ~clk;

    assign flags = {rsp_err, rsp_bypass, rsp_fallback};

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [2:0] flags;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Next state from the polynomial's exponent list: feedback is the parity of bits x^8,x^6,x^5,x^4.
    function automatic logic [7:0] poly_next(input logic [7:0] s);
        int   taps[4] = '{8, 6, 5, 4};
        logic fb;
        fb = 1'b0;
        foreach (taps[i]) fb = fb ^ s[taps[i]-1];
        return {s[6:0], fb};
    endfunction

    // Flags are {err, bypass, fallback}; consumes one LFSR value per rejection-sampling try.
    task automatic model(input logic [7:0] l, input logic [7:0] h,
                         output logic [7:0] d, output logic [2:0] f, output int lat);
        logic [7:0] v;
        if (l > h) begin
            d = 8'd0; f = 3'b100; lat = 1;
        end else if (int'(l) <= THRESH) begin
            d = 8'd0; f = 3'b010; lat = 1;
        end else begin
            d = l; f = 3'b001; lat = MAX_TRIES + 1;
            for (int t = 1; t <= MAX_TRIES; t++) begin
                v  = ml;
                ml = poly_next(ml);
                if (v >= l && v <= h) begin
                    d = v; f = 3'b000; lat = t + 1;
                    break;
                end
            end
        end
    endtask

    task automatic do_req(input logic [7:0] l, input logic [7:0] h, input logic [7:0] ed,
                          input logic [2:0] ef, input int el, input int hold);
        int cyc;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready_before", req_ready, 1);
        req_valid = 1'b1;
        lo = l;
        hi = h;
        @(posedge clk);
        #1;
        // Keep offering garbage while busy; it must be ignored.
        lo = 8'($urandom);
        hi = 8'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 40);
        chk("latency", cyc, el);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_flags", flags, ef);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, ed);
            chk("hold_flags", flags, ef);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_valid", rsp_valid, 0);
        chk("post_flags", flags, 0);
        chk("post_req_ready", req_ready, 1);
    endtask

    task automatic model_req(input logic [7:0] l, input logic [7:0] h, input int hold);
        logic [7:0] ed;
        logic [2:0] ef;
        int         el;
        model(l, h, ed, ef, el);
        do_req(l, h, ed, ef, el, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [7:0] l, h;

        vecs[0] = '{lo: 8'd3,   hi: 8'd200, flags: 3'b010, lat: 1};
        vecs[1] = '{lo: 8'd20,  hi: 8'd10,  flags: 3'b100, lat: 1};
        vecs[2] = '{lo: 8'd5,   hi: 8'd2,   flags: 3'b100, lat: 1};
        vecs[3] = '{lo: 8'd0,   hi: 8'd0,   flags: 3'b010, lat: 1};
        vecs[4] = '{lo: 8'd10,  hi: 8'd255, flags: 3'b010, lat: 1};
        vecs[5] = '{lo: 8'd255, hi: 8'd0,   flags: 3'b100, lat: 1};
        vecs[6] = '{lo: 8'd11,  hi: 8'd10,  flags: 3'b100, lat: 1};

        ml = SEED;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", rsp_valid, 0);
        chk("reset_data", rsp_data, 0);
        chk("reset_flags", flags, 0);
        chk("reset_req_ready", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        foreach (vecs[i]) do_req(vecs[i].lo, vecs[i].hi, 8'd0, vecs[i].flags, vecs[i].lat, 0);

        // First generated value after reset must be the seed itself.
        do_req(8'd11, 8'd255, SEED, 3'b000, 2, 0);
        ml = poly_next(SEED);

        model_req(8'd11, 8'd255, 5);
        for (int i = 0; i < 100; i++) model_req(8'd11, 8'd255, 0);
        for (int i = 0; i < 4; i++) model_req(8'd200, 8'd200, 0);

        for (int i = 0; i < 60; i++) begin
            l = 8'($urandom);
            if ($urandom_range(0, 3) == 0) h = 8'($urandom);
            else h = (int'(l) + $urandom_range(0, 8) > 255) ? 8'd255 : 8'(int'(l) + $urandom_range(0, 8));
            model_req(l, h, $urandom_range(0, 2));
        end

        // Abort mid-generation; the next request must replay the seed sequence.
        @(negedge clk);
        req_valid = 1'b1;
        lo = 8'd250;
        hi = 8'd250;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("gen_valid_low", rsp_valid, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_valid", rsp_valid, 0);
        chk("abort_data", rsp_data, 0);
        chk("abort_flags", flags, 0);
        chk("abort_req_ready", req_ready, 0);
        rst_n = 1'b1;
        ml = SEED;
        @(negedge clk);
        chk("abort_ready_rise", req_ready, 1);
        do_req(8'd11, 8'd255, SEED, 3'b000, 2, 0);
        ml = poly_next(SEED);
        for (int i = 0; i < 5; i++) model_req(8'd11, 8'd255, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
